// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin framer for a UART TX FIFO.
// Each packet goes out as SOF, requester ID, payload bytes, then the XOR checksum of ID and payload.
//
// state   | meaning
// IDLE    | no owner; arbitrate between valid requesters
// SOF     | write the start-of-frame byte
// ID      | write the owner's ID byte
// PAYLOAD | forward owner bytes until one marked last is accepted
// CSUM    | write the checksum, release the grant
module uart_tx_arbiter #(
  parameter logic [7:0] SOF_BYTE = 8'hA5,
  parameter logic [7:0] ID0      = 8'h01,
  parameter logic [7:0] ID1      = 8'h02
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  input  logic       req0_last,
  input  logic       req1_last,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic       is_tx_fifo_full,
  output logic       tx_new_data,
  output logic [7:0] new_data_in,
  output logic [1:0] grant,
  output logic       busy,
  output logic       pkt_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SOF     = 3'd1,
    S_ID      = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] csum;
  logic       ptr;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;
  logic [7:0] id_byte;
  logic       pick;

  assign sel_valid = grant[1] ? req1_valid : req0_valid;
  assign sel_last  = grant[1] ? req1_last  : req0_last;
  assign sel_data  = grant[1] ? req1_data  : req0_data;
  assign id_byte   = grant[1] ? ID1 : ID0;
  // ptr only matters on a tie; a lone valid requester wins outright
  assign pick      = (req0_valid & req1_valid) ? ptr : req1_valid;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req0_valid | req1_valid) state_nxt = S_SOF;
      S_SOF:     if (tx_new_data) state_nxt = S_ID;
      S_ID:      if (tx_new_data) state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (tx_new_data && sel_last) state_nxt = S_CSUM;
      S_CSUM:    if (tx_new_data) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_new_data = 1'b0;
    new_data_in = 8'h00;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state)
      S_SOF: begin
        tx_new_data = ~is_tx_fifo_full;
        new_data_in = SOF_BYTE;
      end
      S_ID: begin
        tx_new_data = ~is_tx_fifo_full;
        new_data_in = id_byte;
      end
      S_PAYLOAD: begin
        req0_ready  = grant[0] & req0_valid & ~is_tx_fifo_full;
        req1_ready  = grant[1] & req1_valid & ~is_tx_fifo_full;
        tx_new_data = sel_valid & ~is_tx_fifo_full;
        new_data_in = sel_data;
      end
      S_CSUM: begin
        tx_new_data = ~is_tx_fifo_full;
        new_data_in = csum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= 2'b00;
      csum     <= 8'h00;
      ptr      <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0_valid | req1_valid) begin
            grant <= pick ? 2'b10 : 2'b01;
            csum  <= 8'h00;
          end
        end
        S_ID:      if (tx_new_data) csum <= csum ^ id_byte;
        S_PAYLOAD: if (tx_new_data) csum <= csum ^ sel_data;
        S_CSUM: begin
          if (tx_new_data) begin
            pkt_done <= 1'b1;
            grant    <= 2'b00;
            ptr      <= grant[0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-cycle compare against a frame-level model, plus literal frame checks.
module tb_uart_tx_arbiter;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_last = 1'b0, req1_last = 1'b0;
  logic       req0_ready, req1_ready;
  logic       is_tx_fifo_full = 1'b0;
  logic       tx_new_data;
  logic [7:0] new_data_in;
  logic [1:0] grant;
  logic       busy;
  logic       pkt_done;

  localparam logic [7:0] SOF = 8'hA5;
  localparam logic [7:0] ID0 = 8'h01;
  localparam logic [7:0] ID1 = 8'h02;

  uart_tx_arbiter dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_last(req0_last), .req1_last(req1_last),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .is_tx_fifo_full(is_tx_fifo_full),
    .tx_new_data(tx_new_data), .new_data_in(new_data_in),
    .grant(grant), .busy(busy), .pkt_done(pkt_done)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // requester sources
  logic [7:0] s_d0[$], s_d1[$];
  bit         s_l0[$], s_l1[$];
  bit         en0 = 0, en1 = 0, full = 0;

  // frame-level model: pending fixed bytes, accepted payload, owner, tie-break pointer
  int         m_owner = -1;
  int         m_ptr = 0;
  logic [7:0] m_hdr[$];
  logic [7:0] m_pay[$];
  bit         m_final = 0;
  bit         m_done = 0;

  // observation logs
  logic [7:0] byte_log[$];
  int         grant_log[$];
  int         last_write_cyc = 0, last_done_cyc = 0;
  int         gap_idle = 0, gap_writes = 0, gap_bad_grant = 0;
  bit         in_gap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input logic [7:0] e[$]);
    chk({name, " length"}, byte_log.size(), e.size());
    for (int i = 0; i < e.size() && i < byte_log.size(); i++)
      chk($sformatf("%s byte %0d", name, i), byte_log[i], e[i]);
  endtask

  task automatic push_pkt(input int who, input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) begin
      if (who == 0) begin s_d0.push_back(b[i]); s_l0.push_back(i == b.size() - 1); end
      else          begin s_d1.push_back(b[i]); s_l1.push_back(i == b.size() - 1); end
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_hdr = {}; m_pay = {}; m_final = 0; m_done = 0;
  endtask

  task automatic clear_logs();
    byte_log = {}; grant_log = {}; gap_idle = 0; gap_writes = 0; gap_bad_grant = 0;
  endtask

  task automatic step_once();
    logic v0, v1, o_valid, e_tx, e_r0, e_r1;
    logic [7:0] e_d, sum;
    logic [1:0] e_g;
    int pre_size;
    @(negedge sys_clk);
    cyc++;
    v0 = en0 && (s_d0.size() > 0);
    v1 = en1 && (s_d1.size() > 0);
    req0_valid = v0;
    req1_valid = v1;
    req0_data  = v0 ? s_d0[0] : 8'($urandom);
    req1_data  = v1 ? s_d1[0] : 8'($urandom);
    req0_last  = v0 ? s_l0[0] : 1'($urandom);
    req1_last  = v1 ? s_l1[0] : 1'($urandom);
    is_tx_fifo_full = full;
    #1;
    e_tx = 0; e_d = 8'h00; e_r0 = 0; e_r1 = 0; o_valid = 0;
    e_g = (m_owner < 0) ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10);
    if (m_owner >= 0) begin
      if (m_hdr.size() > 0) begin
        e_tx = !full;
        e_d  = m_hdr[0];
      end else begin
        o_valid = (m_owner == 0) ? v0 : v1;
        e_tx = o_valid && !full;
        e_d  = (m_owner == 0) ? req0_data : req1_data;
        if (m_owner == 0) e_r0 = e_tx; else e_r1 = e_tx;
      end
    end
    chk("grant", grant, e_g);
    chk("busy", busy, m_owner >= 0);
    chk("pkt_done", pkt_done, m_done);
    chk("tx_new_data", tx_new_data, e_tx);
    chk("new_data_in", new_data_in, e_d);
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);

    pre_size = byte_log.size();
    if (pre_size == 4 && !busy) gap_idle++;
    if (in_gap) begin
      if (tx_new_data || req0_ready || req1_ready) gap_writes++;
      if (grant != 2'b10) gap_bad_grant++;
    end
    if (tx_new_data && !is_tx_fifo_full) begin
      byte_log.push_back(new_data_in);
      last_write_cyc = cyc;
    end
    if (pkt_done) last_done_cyc = cyc;

    m_done = 0;
    if (m_owner < 0) begin
      if (v0 || v1) begin
        m_owner = (v0 && v1) ? m_ptr : (v1 ? 1 : 0);
        m_hdr = {SOF, (m_owner == 0) ? ID0 : ID1};
        m_pay = {};
        m_final = 0;
        grant_log.push_back(m_owner);
      end
    end else if (m_hdr.size() > 0) begin
      if (!full) begin
        void'(m_hdr.pop_front());
        if (m_final) begin
          m_ptr = 1 - m_owner;
          m_owner = -1;
          m_done = 1;
        end
      end
    end else if (e_tx) begin
      bit last;
      if (m_owner == 0) begin m_pay.push_back(s_d0.pop_front()); last = s_l0.pop_front(); end
      else              begin m_pay.push_back(s_d1.pop_front()); last = s_l1.pop_front(); end
      if (last) begin
        sum = (m_owner == 0) ? ID0 : ID1;
        foreach (m_pay[i]) sum ^= m_pay[i];
        m_hdr = {sum};
        m_final = 1;
      end
    end
  endtask

  task automatic run_until(input string name, input int n_bytes, input int budget);
    int k = 0;
    while (byte_log.size() < n_bytes && k < budget) begin step_once(); k++; end
    if (byte_log.size() < n_bytes) chk({name, " timeout"}, byte_log.size(), n_bytes);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    chk("rst grant", grant, 2'b00);
    chk("rst busy", busy, 1'b0);
    chk("rst pkt_done", pkt_done, 1'b0);
    chk("rst tx_new_data", tx_new_data, 1'b0);
    chk("rst new_data_in", new_data_in, 8'h00);
    chk("rst ready", {req0_ready, req1_ready}, 2'b00);
    req0_valid = 0; req1_valid = 0;
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] e[$];
    int txs;

    // one-packet frame with checksum 01^10^20
    do_reset(); clear_logs(); en0 = 1; en1 = 0; full = 0;
    push_pkt(0, '{8'h10, 8'h20});
    run_until("basic", 5, 40);
    repeat (2) step_once();
    e = '{8'hA5, 8'h01, 8'h10, 8'h20, 8'h31};
    chk_log("basic frame", e);
    chk("basic done latency", last_done_cyc, last_write_cyc + 1);
    chk("basic grants", grant_log.size(), 1);

    // tie from reset goes to requester 0 first, then 1
    do_reset(); clear_logs(); en0 = 1; en1 = 1;
    push_pkt(0, '{8'hFF}); push_pkt(1, '{8'hFF});
    run_until("tie", 8, 60);
    repeat (2) step_once();
    e = '{8'hA5, 8'h01, 8'hFF, 8'hFE, 8'hA5, 8'h02, 8'hFF, 8'hFD};
    chk_log("tie frames", e);
    chk("tie grant count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("tie first grant", grant_log[0], 0);
      chk("tie second grant", grant_log[1], 1);
    end

    // FIFO full held over the ID byte
    do_reset(); clear_logs(); en0 = 1; en1 = 0;
    push_pkt(0, '{8'h33});
    repeat (2) step_once();
    full = 1; txs = 0;
    repeat (5) begin step_once(); if (tx_new_data) txs++; end
    chk("full hold writes", txs, 0);
    full = 0;
    step_once();
    chk("full release id written", byte_log.size(), 2);
    run_until("full", 4, 40);
    e = '{8'hA5, 8'h01, 8'h33, 8'h32};
    chk_log("full frame", e);

    // requester 1 stalls mid-payload
    do_reset(); clear_logs(); en0 = 0; en1 = 1;
    push_pkt(1, '{8'h11, 8'h22, 8'h44});
    run_until("stall", 3, 40);
    en1 = 0; in_gap = 1;
    repeat (3) step_once();
    in_gap = 0; en1 = 1;
    chk("stall gap writes", gap_writes, 0);
    chk("stall gap grant", gap_bad_grant, 0);
    run_until("stall", 6, 40);
    e = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h44, 8'h75};
    chk_log("stall frame", e);

    // reset during requester 1 payload abandons the frame
    do_reset(); clear_logs(); en0 = 0; en1 = 1;
    push_pkt(1, '{8'h66, 8'h77, 8'h88});
    run_until("midrst", 3, 40);
    do_reset();
    s_d0 = {}; s_l0 = {}; s_d1 = {}; s_l1 = {};
    clear_logs(); en0 = 1; en1 = 1;
    push_pkt(0, '{8'h01}); push_pkt(1, '{8'h02});
    run_until("midrst", 8, 60);
    e = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'hA5, 8'h02, 8'h02, 8'h00};
    chk_log("midrst frames", e);
    if (grant_log.size() > 0) chk("midrst first grant", grant_log[0], 0);

    // single-byte payloads back to back: one idle cycle between frames
    do_reset(); clear_logs(); en0 = 1; en1 = 0;
    push_pkt(0, '{8'h01}); push_pkt(0, '{8'h05});
    run_until("b2b", 8, 60);
    e = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'hA5, 8'h01, 8'h05, 8'h04};
    chk_log("b2b frames", e);
    chk("b2b idle gap", gap_idle, 1);

    // random traffic against the model
    do_reset(); clear_logs();
    s_d0 = {}; s_l0 = {}; s_d1 = {}; s_l1 = {};
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] pk[$];
      for (int w = 0; w < 2; w++) begin
        if ((w == 0 ? s_d0.size() : s_d1.size()) == 0) begin
          pk = {};
          for (int b = 0; b < $urandom_range(1, 5); b++) pk.push_back(8'($urandom));
          push_pkt(w, pk);
        end
      end
      en0 = ($urandom_range(0, 3) != 0);
      en1 = ($urandom_range(0, 3) != 0);
      full = ($urandom_range(0, 3) == 0);
      step_once();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL take parameter SOF_BYTE, default 8'hA5, which is the start-of-frame byte emitted ahead of every packet.
REQ-002 The block SHALL take parameter ID0, default 8'h01, which is the ID byte emitted for requester 0.
REQ-003 The block SHALL take parameter ID1, default 8'h02, which is the ID byte emitted for requester 1.
REQ-004 The block SHALL have port sys_clk  input  1  system clock; the block uses one clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have ports req0_valid, req1_valid  input  1 each  requester has a payload byte available.
REQ-007 The block SHALL have ports req0_data, req1_data  input  8 each  requester payload byte.
REQ-008 The block SHALL have ports req0_last, req1_last  input  1 each  current byte is the final payload byte.
REQ-009 The block SHALL have ports req0_ready, req1_ready  output  1 each  payload byte accepted this cycle.
REQ-010 The block SHALL have port is_tx_fifo_full  input  1  TX FIFO full flag from the UART FIFO wrapper.
REQ-011 The block SHALL have port tx_new_data  output  1  TX FIFO write strobe; the FIFO writes on tx_new_data & ~is_tx_fifo_full.
REQ-012 The block SHALL have port new_data_in  output  8  byte presented to the TX FIFO.
REQ-013 The block SHALL have port grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-014 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 The block SHALL have port pkt_done  output  1  one-cycle pulse after the checksum byte is written.

Function
REQ-016 The FSM SHALL have states IDLE, SOF, ID, PAYLOAD and CSUM.
REQ-017 In IDLE with any reqN_valid high, the block SHALL grant by round-robin (pointer favours the requester not served last), load grant, clear the checksum and go to SOF next cycle.
REQ-018 With both requesters valid in IDLE, the block SHALL grant the pointer's requester; after reset the pointer favours requester 0.
REQ-019 In SOF, ID and CSUM, tx_new_data SHALL equal ~is_tx_fifo_full (combinational), with new_data_in = SOF_BYTE, IDn and the checksum respectively.
REQ-020 Each of SOF, ID and CSUM SHALL advance on the cycle its byte is written, and hold while is_tx_fifo_full is high.
REQ-021 In PAYLOAD, reqN_ready SHALL equal grant[N] & reqN_valid & ~is_tx_fifo_full, tx_new_data SHALL equal that same term, and new_data_in SHALL equal reqN_data.
REQ-022 The non-granted requester's ready SHALL be 0 at all times.
REQ-023 The checksum SHALL be an 8-bit XOR of the ID byte and every accepted payload byte, updated on each written byte; overflow is not possible.
REQ-024 An accepted byte with reqN_last=1 SHALL move PAYLOAD to CSUM; a packet with a one-byte payload is legal.
REQ-025 A write of the CSUM byte SHALL return the FSM to IDLE, pulse pkt_done for one cycle, clear grant, and set the pointer to the other requester.
REQ-026 A granted requester dropping valid mid-packet SHALL stall PAYLOAD indefinitely with no timeout; the grant SHALL NOT be revoked.
REQ-027 A requester asserting valid mid-packet SHALL wait; it is served in the next IDLE arbitration.
REQ-028 In IDLE, tx_new_data SHALL be 0 and new_data_in SHALL be 8'h00.
REQ-029 The FSM SHALL spend exactly one IDLE cycle between back-to-back packets.

Reset
REQ-030 On rst_n low, asynchronously: state IDLE, grant 2'b00, checksum 8'h00, pointer to requester 0, pkt_done 0, busy 0, tx_new_data 0, both readies 0, new_data_in 8'h00.
REQ-031 Reset mid-packet SHALL abandon the frame with no checksum written; after release, arbitration restarts with requester 0 favoured.

Verification
REQ-032 Req0 sends {8'h10, 8'h20 last}, FIFO never full -> bytes A5,01,10,20,31 on consecutive write cycles, pkt_done one cycle after the 31 write, grant 01 throughout.
REQ-033 Both requesters valid from reset, each sending one byte 8'hFF -> frame A5,01,FF,FE, then A5,02,FF,FD; grant order 01, 10.
REQ-034 is_tx_fifo_full held high for 5 cycles during ID -> tx_new_data low, state held, no byte lost; ID byte written the cycle full drops.
REQ-035 Req1 drops valid for 3 cycles mid-payload -> no writes and no ready during the gap, grant stays 10, checksum correct at the end.
REQ-036 rst_n pulsed low during PAYLOAD of req1 -> outputs take reset values immediately; next frame with both valid grants requester 0.
REQ-037 Single-byte payload 8'h01 from req0 -> frame A5,01,01,00; busy low exactly one cycle before the next packet.
